mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 multiply / divide unit.
//
// Multiply uses radix-2 Booth recoding, one step per cycle on a 65-bit
// accumulator {upper[31:0], lower[31:0], qMinus1}. Divide uses restoring
// division on operand magnitudes, one quotient bit per cycle, with signs
// fixed up when the result is written. Both take exactly 32 iteration
// cycles followed by a single DONE cycle.
//
// Ports:
//   Clk      in   system clock, rising-edge
//   Reset    in   synchronous active-high reset
//   Start    in   request, sampled only in IDLE
//   Op       in   0 = signed multiply, 1 = signed divide
//   A        in   [31:0] multiplicand / dividend
//   B        in   [31:0] multiplier / divisor
//   Busy     out  high while iterating
//   Done     out  one-cycle pulse, Hi/Lo valid from this cycle
//   Hi       out  [31:0] product[63:32] or remainder
//   Lo       out  [31:0] product[31:0] or quotient
//   DivZero  out  pulse with Done when a divide by zero is short-circuited
//
// Configuration:
//   MDU_DIVZERO_DETECT_EN  when defined, a divide with B=0 skips iteration and
//                          goes straight to DONE with DivZero=1 and Hi/Lo
//                          unchanged. When undefined, DivZero is tied low and
//                          a divide by zero runs the full 32 cycles, giving
//                          Hi=A and Lo=0xFFFFFFFF.

module mult_div_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivZero
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMult = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  stateQ, stateD;
  logic [4:0]  cntQ, cntD;
  logic [31:0] aQ, aD;             // original A: multiplicand, dividend sign
  logic [31:0] divisorQ, divisorD; // |B|
  logic        signQuoQ, signQuoD;
  logic [64:0] accQ, accD;
  logic [31:0] remQ, remD;
  logic [31:0] quoQ, quoD;
  logic [31:0] hiQ, hiD;
  logic [31:0] loQ, loD;

  // Operand magnitudes; |-2^31| = 0x80000000 is still correct as unsigned.
  logic [31:0] absA, absB;
  assign absA = A[31] ? (~A + 32'd1) : A;
  assign absB = B[31] ? (~B + 32'd1) : B;

  // Booth step. The add is done in 33 bits so that subtracting -2^31 cannot
  // overflow; the extra bit becomes the sign shifted into the accumulator.
  logic [32:0] mcand33;
  logic [32:0] boothSum;
  logic [64:0] accStep;
  assign mcand33 = {aQ[31], aQ};

  always_comb begin
    boothSum = {accQ[64], accQ[64:33]};
    unique case (accQ[1:0])
      2'b01:   boothSum = boothSum + mcand33;
      2'b10:   boothSum = boothSum - mcand33;
      default: boothSum = boothSum;
    endcase
    accStep = {boothSum, accQ[32:1]};
  end

  // Restoring divide step on magnitudes. The partial remainder is always
  // below the divisor (<= 2^31), so the shifted value fits in 33 bits and
  // bit 32 of the difference is a clean borrow flag.
  logic [32:0] remShift;
  logic [32:0] remDiff;
  logic [31:0] remStep;
  logic [31:0] quoStep;
  logic [31:0] quoFinal;
  logic [31:0] remFinal;

  always_comb begin
    remShift = {remQ, quoQ[31]};
    remDiff  = remShift - {1'b0, divisorQ};
    if (!remDiff[32]) begin
      remStep = remDiff[31:0];
      quoStep = {quoQ[30:0], 1'b1};
    end else begin
      remStep = remShift[31:0];
      quoStep = {quoQ[30:0], 1'b0};
    end
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quoFinal = signQuoQ ? (~quoStep + 32'd1) : quoStep;
    remFinal = aQ[31] ? (~remStep + 32'd1) : remStep;
  end

`ifdef MDU_DIVZERO_DETECT_EN
  logic dzQ, dzD;
`endif

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    aD       = aQ;
    divisorD = divisorQ;
    signQuoD = signQuoQ;
    accD     = accQ;
    remD     = remQ;
    quoD     = quoQ;
    hiD      = hiQ;
    loD      = loQ;
`ifdef MDU_DIVZERO_DETECT_EN
    dzD      = dzQ;
`endif

    unique case (stateQ)
      StIdle: begin
        if (Start) begin
          aD       = A;
          divisorD = absB;
          signQuoD = A[31] ^ B[31];
          cntD     = 5'd0;
          accD     = {32'd0, B, 1'b0};
          remD     = 32'd0;
          quoD     = absA;
          stateD   = Op ? StDiv : StMult;
`ifdef MDU_DIVZERO_DETECT_EN
          dzD      = 1'b0;
          if (Op && (B == 32'd0)) begin
            stateD = StDone;
            dzD    = 1'b1;
          end
`endif
        end
      end

      StMult: begin
        accD = accStep;
        cntD = cntQ + 5'd1;
        if (cntQ == 5'd31) begin
          stateD = StDone;
          hiD    = accStep[64:33];
          loD    = accStep[32:1];
        end
      end

      StDiv: begin
        remD = remStep;
        quoD = quoStep;
        cntD = cntQ + 5'd1;
        if (cntQ == 5'd31) begin
          stateD = StDone;
          if (divisorQ == 32'd0) begin
            // Sign fix-up would corrupt the all-ones quotient; report raw.
            hiD = aQ;
            loD = 32'hFFFF_FFFF;
          end else begin
            hiD = remFinal;
            loD = quoFinal;
          end
        end
      end

      StDone: begin
        // Start in this cycle is deliberately ignored.
        stateD = StIdle;
      end

      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ   <= StIdle;
      cntQ     <= 5'd0;
      aQ       <= 32'd0;
      divisorQ <= 32'd0;
      signQuoQ <= 1'b0;
      accQ     <= 65'd0;
      remQ     <= 32'd0;
      quoQ     <= 32'd0;
      hiQ      <= 32'd0;
      loQ      <= 32'd0;
`ifdef MDU_DIVZERO_DETECT_EN
      dzQ      <= 1'b0;
`endif
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      aQ       <= aD;
      divisorQ <= divisorD;
      signQuoQ <= signQuoD;
      accQ     <= accD;
      remQ     <= remD;
      quoQ     <= quoD;
      hiQ      <= hiD;
      loQ      <= loD;
`ifdef MDU_DIVZERO_DETECT_EN
      dzQ      <= dzD;
`endif
    end
  end

  assign Busy = (stateQ == StMult) || (stateQ == StDiv);
  assign Done = (stateQ == StDone);
  assign Hi   = hiQ;
  assign Lo   = loQ;

`ifdef MDU_DIVZERO_DETECT_EN
  assign DivZero = Done && dzQ;
`else
  assign DivZero = 1'b0;
`endif

endmodule
